text_row_prefetcher: RTL and testbench

//  Sequences scan-out of the 1280x800 text mode: prefetches each 160-char text row from the external

---
 rtl/text_row_prefetcher.sv | 171 +++++++++++++++++
 tb/tb_text_row_prefetcher.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_row_prefetcher.sv
// text_row_prefetcher: prefetches each text row of the 1280x800 text mode from the
// character RAM into a double line buffer ahead of display. The single-port RAM is
// shared round-robin between prefetch reads and a host write port.
module text_row_prefetcher #(
  parameter int COLS      = 160,
  parameter int ROWS      = 50,
  parameter int CHAR_H    = 16,
  parameter int H_TOTAL   = 1440,
  parameter int V_VISIBLE = 800,
  parameter int V_TOTAL   = 831,
  parameter int ADDR_W    = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic [7:0]        disp_col,
  output logic [7:0]        disp_char,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_data,
  output logic              host_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              fetch_busy,
  output logic              underrun
);

  localparam int CW  = $clog2(COLS + 1);
  localparam int CIW = $clog2(COLS);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FETCH = 1'b1;

  logic [0:0]        state;
  logic              active_buf;
  logic              tgt_buf;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0]     issue_col;
  logic [CIW-1:0]    col_p1;
  logic [CIW-1:0]    col_p2;
  logic              rd_p1;
  logic              rd_p2;
  logic              prev_read;
  logic [7:0]        lbuf [0:1][0:COLS-1];

  logic       line_end;
  logic       row_trig;
  logic       frame_trig;
  logic       wrap_trig;
  logic       trig_swap;
  logic       trig_fetch;
  logic       any_trig;
  logic [9:0] vrow;
  logic [9:0] vphase;
  logic [9:0] fetch_row;
  logic       read_avail;
  logic       host_grant;
  logic       do_read;
  logic       host_in_range;
  logic       cap_en;

  // Decode line-end triggers: row boundaries, end of visible area, end of frame.
  always_comb begin
    line_end   = (hcount == 11'(H_TOTAL - 1));
    vrow       = vcount / 10'(CHAR_H);
    vphase     = vcount % 10'(CHAR_H);
    row_trig   = line_end && (vphase == 10'(CHAR_H - 1)) && (vrow <= 10'(ROWS - 2));
    frame_trig = line_end && (vcount == 10'(V_VISIBLE - 1));
    wrap_trig  = line_end && (vcount == 10'(V_TOTAL - 1));
    trig_swap  = row_trig || wrap_trig;
    trig_fetch = (row_trig && ((vrow + 10'd2) < 10'(ROWS))) || frame_trig || wrap_trig;
    any_trig   = trig_swap || trig_fetch;
    fetch_row  = '0;
    if (row_trig)
      fetch_row = vrow + 10'd2;
    else if (wrap_trig)
      fetch_row = 10'd1;
  end

  // RAM slot arbitration: host gets the slot after any read, or any slot with no read pending.
  // A trigger cycle issues no read, so the in-flight pipeline can be flushed cleanly.
  always_comb begin
    read_avail    = (state == S_FETCH) && (issue_col < CW'(COLS)) && !any_trig;
    host_grant    = host_req && !host_ack && ((state == S_IDLE) || prev_read || !read_avail);
    do_read       = read_avail && !host_grant;
    host_in_range = (host_addr < ADDR_W'(COLS * ROWS));
    cap_en        = (state == S_FETCH) && rd_p2 && !any_trig;
  end

  assign fetch_busy = (state == S_FETCH);

  // Display read from the active line buffer; out-of-range columns read as blank.
  always_comb begin
    disp_char = 8'h00;
    if (disp_col < 8'(COLS))
      disp_char = lbuf[active_buf][CIW'(disp_col)];
  end

  // Control: FSM, buffer swap, RAM port registers, read pipeline and host handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      active_buf <= 1'b0;
      tgt_buf    <= 1'b0;
      base       <= '0;
      issue_col  <= '0;
      col_p1     <= '0;
      col_p2     <= '0;
      rd_p1      <= 1'b0;
      rd_p2      <= 1'b0;
      prev_read  <= 1'b0;
      host_ack   <= 1'b0;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_wdata  <= '0;
      underrun   <= 1'b0;
    end else begin
      host_ack  <= host_grant;
      prev_read <= do_read;
      ram_we    <= 1'b0;
      if (host_grant) begin
        if (host_in_range) begin
          ram_we    <= 1'b1;
          ram_addr  <= host_addr;
          ram_wdata <= host_data;
        end
      end else if (do_read) begin
        ram_addr  <= base + ADDR_W'(issue_col);
        issue_col <= issue_col + 1'b1;
      end
      rd_p1  <= do_read;
      col_p1 <= CIW'(issue_col);
      rd_p2  <= rd_p1;
      col_p2 <= col_p1;
      if (any_trig) begin
        if (trig_swap)
          active_buf <= ~active_buf;
        if (state == S_FETCH)
          underrun <= 1'b1;
        rd_p1 <= 1'b0;
        rd_p2 <= 1'b0;
        if (trig_fetch) begin
          state     <= S_FETCH;
          base      <= ADDR_W'(fetch_row) * ADDR_W'(COLS);
          issue_col <= '0;
          // Target is whichever buffer is inactive once this trigger's swap has applied.
          tgt_buf   <= trig_swap ? active_buf : ~active_buf;
        end else begin
          state <= S_IDLE;
        end
      end else if (cap_en && (col_p2 == CIW'(COLS - 1))) begin
        state <= S_IDLE;
      end
    end
  end

  // Line buffer storage: captures returning RAM data into the fetch target buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned c = 0; c < COLS; c++)
          lbuf[b[0]][CIW'(c)] <= 8'h00;
    end else if (cap_en) begin
      lbuf[tgt_buf][col_p2] <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_text_row_prefetcher.sv
// Testbench for text_row_prefetcher: synchronous RAM model, randomized contents and
// host traffic, expected characters derived from the frame schedule and a shadow copy.
module tb_text_row_prefetcher;
  localparam int COLS = 160;
  localparam int ROWS = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [7:0]  disp_col;
  logic [7:0]  disp_char;
  logic        host_req;
  logic [12:0] host_addr;
  logic [7:0]  host_data;
  logic        host_ack;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        fetch_busy;
  logic        underrun;

  int tests = 0;
  int fails = 0;

  // RAM model: untouched locations read a deterministic pattern, written ones their data.
  logic [7:0] mem [8192];
  bit         wr  [8192];
  // Bench's own record of intended host writes.
  logic [7:0] sh    [8192];
  bit         sh_wr [8192];
  int         pat_mode = 0;
  logic [7:0] seed = 8'h00;

  always #5 clk = ~clk;

  text_row_prefetcher #(
    .COLS(160), .ROWS(50), .CHAR_H(16), .H_TOTAL(1440),
    .V_VISIBLE(800), .V_TOTAL(831), .ADDR_W(13)
  ) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .disp_col(disp_col), .disp_char(disp_char),
    .host_req(host_req), .host_addr(host_addr), .host_data(host_data), .host_ack(host_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .fetch_busy(fetch_busy), .underrun(underrun)
  );

  function automatic logic [7:0] pattern(input int a);
    if (pat_mode == 0)
      return a[7:0];
    return 8'(a * 37) ^ 8'(a >> 5) ^ seed;
  endfunction

  function automatic logic [7:0] exp_byte(input int a);
    return sh_wr[a] ? sh[a] : pattern(a);
  endfunction

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr[ram_addr]  <= 1'b1;
    end
    ram_rdata <= wr[ram_addr] ? mem[ram_addr] : pattern(int'(ram_addr));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle line_end at the given line.
  task automatic pulse(input int v);
    vcount = 10'(v);
    hcount = 11'd1439;
    tick();
    hcount = 11'd0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (fetch_busy && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    tests++;
    if ({host_ack, ram_we, fetch_busy, underrun} !== 4'b0 || ram_addr !== 13'd0 ||
        ram_wdata !== 8'd0 || disp_char !== 8'd0) begin
      fails++;
      $display("FAIL reset_outputs: ack=%0b we=%0b busy=%0b und=%0b addr=%0d wdata=%0h char=%0h, want all 0",
               host_ack, ram_we, fetch_busy, underrun, ram_addr, ram_wdata, disp_char);
    end
    reset = 1'b0;
    tick();
    pulse(799); wait_idle();
    pulse(830); wait_idle();
    disp_col = 8'd3; #1;
    tests++;
    if (disp_char !== exp_byte(3)) begin
      fails++; $display("FAIL reset_predata: got %0h, want %0h", disp_char, exp_byte(3));
    end
    pulse(15);
    repeat (20) tick();
    tests++;
    if (fetch_busy !== 1'b1) begin
      fails++; $display("FAIL reset_midfetch_busy: got %0b, want 1", fetch_busy);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({host_ack, ram_we, underrun} !== 3'b0 || ram_addr !== 13'd0 || ram_wdata !== 8'd0) begin
      fails++;
      $display("FAIL reset_async: ack=%0b we=%0b und=%0b addr=%0d wdata=%0h, want 0",
               host_ack, ram_we, underrun, ram_addr, ram_wdata);
    end
    for (int k = 0; k < 4; k++) begin
      disp_col = (k == 3) ? 8'd200 : 8'(k * 53);
      #1;
      tests++;
      if (disp_char !== 8'h00) begin
        fails++; $display("FAIL reset_disp[%0d]: got %0h, want 00", disp_col, disp_char);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    tick();
    tests++;
    if (fetch_busy !== 1'b0 || underrun !== 1'b0) begin
      fails++; $display("FAIL reset_after: busy=%0b und=%0b, want 0 0", fetch_busy, underrun);
    end
  endtask

  task automatic test_frame_prefetch();
    int n;
    pulse(799);
    tests++;
    if (fetch_busy !== 1'b1) begin
      fails++; $display("FAIL fp_busy_rise: got %0b, want 1", fetch_busy);
    end
    tick();
    for (int i = 0; i < COLS; i++) begin
      tests++;
      if (ram_addr !== 13'(i) || ram_we !== 1'b0) begin
        fails++; $display("FAIL fp_addr[%0d]: addr=%0d we=%0b, want addr=%0d we=0", i, ram_addr, ram_we, i);
      end
      tick();
    end
    n = 0;
    while (fetch_busy && n < 4) begin
      tick();
      n++;
    end
    tests++;
    if (fetch_busy !== 1'b0) begin
      fails++; $display("FAIL fp_busy_fall: got %0b, want 0", fetch_busy);
    end
    pulse(830);
    disp_col = 8'd5; #1;
    tests++;
    if (disp_char !== 8'h05) begin
      fails++; $display("FAIL fp_col5: got %0h, want 05", disp_char);
    end
    for (int c = 0; c < COLS; c++) begin
      disp_col = 8'(c); #1;
      tests++;
      if (disp_char !== exp_byte(c)) begin
        fails++; $display("FAIL fp_row0[%0d]: got %0h, want %0h", c, disp_char, exp_byte(c));
      end
    end
    disp_col = 8'd200; #1;
    tests++;
    if (disp_char !== 8'h00) begin
      fails++; $display("FAIL fp_col_oob: got %0h, want 00", disp_char);
    end
    wait_idle();
  endtask

  task automatic test_row_pipeline();
    int c;
    pat_mode = 1;
    seed = 8'($urandom);
    pulse(799); wait_idle();
    pulse(830); wait_idle();
    for (int row = 0; row < ROWS; row++) begin
      if (row > 0) begin
        pulse(16 * (row - 1) + 15);
        wait_idle();
        tests++;
        if (fetch_busy !== 1'b0) begin
          fails++; $display("FAIL rp_busy[%0d]: got 1, want 0", row);
        end
      end
      for (int k = 0; k < 5; k++) begin
        c = $urandom_range(COLS - 1);
        disp_col = 8'(c); #1;
        tests++;
        if (disp_char !== exp_byte(row * COLS + c)) begin
          fails++;
          $display("FAIL rp_row%0d[%0d]: got %0h, want %0h", row, c, disp_char, exp_byte(row * COLS + c));
        end
      end
    end
    tests++;
    if (underrun !== 1'b0) begin
      fails++; $display("FAIL rp_underrun: got %0b, want 0", underrun);
    end
  endtask

  task automatic test_host_idle();
    host_addr = 13'd200; host_data = 8'h41; host_req = 1'b1;
    tick();
    tests++;
    if (ram_we !== 1'b1 || ram_addr !== 13'd200 || ram_wdata !== 8'h41 || host_ack !== 1'b1) begin
      fails++;
      $display("FAIL hi_grant: we=%0b addr=%0d wdata=%0h ack=%0b, want 1 200 41 1", ram_we, ram_addr, ram_wdata, host_ack);
    end
    host_req = 1'b0;
    sh[200] = 8'h41; sh_wr[200] = 1'b1;
    tick();
    tests++;
    if (host_ack !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 13'd200) begin
      fails++;
      $display("FAIL hi_after: ack=%0b we=%0b addr=%0d, want 0 0 200", host_ack, ram_we, ram_addr);
    end
    tests++;
    if (mem[200] !== 8'h41) begin
      fails++; $display("FAIL hi_landed: mem=%0h, want 41", mem[200]);
    end
  endtask

  task automatic test_back_to_back();
    int         wa [10];
    logic [7:0] wd [10];
    int         last_cyc, done_cyc, acks, b2b, n;
    logic       pw;
    last_cyc = -1; done_cyc = -1; acks = 0; b2b = 0; pw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      wa[k] = 1600 + k * 53 + $urandom_range(40);
      wd[k] = 8'($urandom);
    end
    pulse(15);  // swap, fetch row 2
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          host_req = 1'b1; host_addr = 13'(wa[k]); host_data = wd[k];
          tick();
          n = 0;
          while (!host_ack && n < 20) begin
            tick();
            n++;
          end
          if (host_ack) acks++;
        end
        host_req = 1'b0;
      end
      begin
        for (int c = 1; c < 400; c++) begin
          if (ram_we && pw) b2b++;
          pw = ram_we;
          if (c >= 2 && !ram_we && ram_addr == 13'(3 * COLS - 1) && last_cyc < 0) last_cyc = c;
          if (!fetch_busy) begin
            done_cyc = c;
            break;
          end
          tick();
        end
      end
    join
    tests++;
    if (acks != 10) begin
      fails++; $display("FAIL bb_acks: got %0d, want 10", acks);
    end
    tests++;
    if (b2b != 0) begin
      fails++; $display("FAIL bb_alternate: %0d consecutive write slots, want 0", b2b);
    end
    tests++;
    if (last_cyc < 2 || last_cyc > 171) begin
      fails++; $display("FAIL bb_last_read: last read on bus at cycle %0d, want 2..171", last_cyc);
    end
    tests++;
    if (done_cyc < 0 || done_cyc > 2 * COLS + 2) begin
      fails++; $display("FAIL bb_fetch_done: busy fell at cycle %0d, want <= %0d", done_cyc, 2 * COLS + 2);
    end
    for (int k = 0; k < 10; k++) begin
      sh[wa[k]] = wd[k]; sh_wr[wa[k]] = 1'b1;
      tests++;
      if (mem[wa[k]] !== wd[k]) begin
        fails++; $display("FAIL bb_write[%0d]: mem[%0d]=%0h, want %0h", k, wa[k], mem[wa[k]], wd[k]);
      end
    end
    pulse(31);  // row 2 becomes active
    for (int c = 0; c < COLS; c++) begin
      disp_col = 8'(c); #1;
      tests++;
      if (disp_char !== exp_byte(2 * COLS + c)) begin
        fails++; $display("FAIL bb_row2[%0d]: got %0h, want %0h", c, disp_char, exp_byte(2 * COLS + c));
      end
    end
    wait_idle();
    tests++;
    if (underrun !== 1'b0) begin
      fails++; $display("FAIL bb_underrun: got %0b, want 0", underrun);
    end
  endtask

  task automatic test_preempt_range();
    int c;
    pulse(799);
    repeat (49) tick();
    tests++;
    if (fetch_busy !== 1'b1) begin
      fails++; $display("FAIL pr_busy_mid: got %0b, want 1", fetch_busy);
    end
    pulse(15);  // abandons row 0, fetches row 2
    tests++;
    if (underrun !== 1'b1 || fetch_busy !== 1'b1) begin
      fails++; $display("FAIL pr_underrun: und=%0b busy=%0b, want 1 1", underrun, fetch_busy);
    end
    tick();
    tests++;
    if (ram_addr !== 13'd320 || ram_we !== 1'b0) begin
      fails++; $display("FAIL pr_restart0: addr=%0d we=%0b, want 320 0", ram_addr, ram_we);
    end
    tick();
    tests++;
    if (ram_addr !== 13'd321) begin
      fails++; $display("FAIL pr_restart1: addr=%0d, want 321", ram_addr);
    end
    wait_idle();
    pulse(31);
    for (int k = 0; k < 8; k++) begin
      c = $urandom_range(COLS - 1);
      disp_col = 8'(c); #1;
      tests++;
      if (disp_char !== exp_byte(2 * COLS + c)) begin
        fails++; $display("FAIL pr_row2[%0d]: got %0h, want %0h", c, disp_char, exp_byte(2 * COLS + c));
      end
    end
    wait_idle();
    host_addr = 13'd8000; host_data = 8'($urandom); host_req = 1'b1;
    tick();
    tests++;
    if (host_ack !== 1'b1 || ram_we !== 1'b0) begin
      fails++; $display("FAIL pr_oob_write: ack=%0b we=%0b, want 1 0", host_ack, ram_we);
    end
    host_req = 1'b0;
    tick();
    tests++;
    if (host_ack !== 1'b0 || wr[8000] !== 1'b0) begin
      fails++; $display("FAIL pr_oob_after: ack=%0b written=%0b, want 0 0", host_ack, wr[8000]);
    end
    tests++;
    if (underrun !== 1'b1) begin
      fails++; $display("FAIL pr_sticky: got %0b, want 1", underrun);
    end
  endtask

  task automatic test_swap_with_host();
    int         a, c;
    logic [7:0] d;
    a = 4000 + $urandom_range(100);
    d = 8'($urandom);
    host_req = 1'b1; host_addr = 13'(a); host_data = d;
    pulse(47);  // swap to row 3 and host grant in the same cycle
    tests++;
    if (host_ack !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 13'(a) || ram_wdata !== d) begin
      fails++;
      $display("FAIL sh_grant: ack=%0b we=%0b addr=%0d wdata=%0h, want 1 1 %0d %0h", host_ack, ram_we, ram_addr, ram_wdata, a, d);
    end
    host_req = 1'b0;
    sh[a] = d; sh_wr[a] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      c = $urandom_range(COLS - 1);
      disp_col = 8'(c); #1;
      tests++;
      if (disp_char !== exp_byte(3 * COLS + c)) begin
        fails++; $display("FAIL sh_row3[%0d]: got %0h, want %0h", c, disp_char, exp_byte(3 * COLS + c));
      end
    end
    wait_idle();
    tests++;
    if (mem[a] !== d) begin
      fails++; $display("FAIL sh_landed: mem[%0d]=%0h, want %0h", a, mem[a], d);
    end
  endtask

  initial begin
    reset = 1'b1; hcount = 11'd0; vcount = 10'd0; disp_col = 8'd0;
    host_req = 1'b0; host_addr = 13'd0; host_data = 8'd0;
    test_reset();
    test_frame_prefetch();
    test_row_pipeline();
    test_host_idle();
    test_back_to_back();
    test_preempt_range();
    test_swap_with_host();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
